// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, control-word field positions and encodings for the decode stage
package rv_ctrl_pkg;
    localparam int CTRL_W = 18;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam int B_REG_WRITE = 0;
    localparam int B_MEM_TO_REG = 1;
    localparam int B_MEM_READ = 2;
    localparam int B_MEM_WRITE = 3;
    localparam int B_BRANCH = 4;
    localparam int B_JUMP = 5;
    localparam int B_ALU_SRC = 6;
    localparam int ALU_LSB = 7;
    localparam int IMM_LSB = 11;
    localparam int PCS_LSB = 14;
    localparam int B_ASEL_PC = 16;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b1010;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic [1:0] PCS_JAL = 2'b10;
    localparam logic [1:0] PCS_JALR = 2'b11;
endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: combinational RV32 decode into control word, illegal flag and source-use flags
//   instr_i    instruction word
//   ctrl_o     control word (zero when illegal)
//   illegal_o  unknown opcode, bad funct7 or register index out of range
//   use_rs1_o / use_rs2_o  instruction reads rs1 / rs2
module rv_decode_comb
    import rv_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [31:0]       instr_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o,
    output logic              use_rs1_o,
    output logic              use_rs2_o
);
    localparam logic [5:0] NR = 6'(NUM_REGS);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [CTRL_W-1:0] c;
    logic bad, use_rd, u1, u2, oob;
    assign op = instr_i[6:0];
    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];
    always_comb begin
        c = '0;
        bad = 1'b0;
        use_rd = 1'b0;
        u1 = 1'b0;
        u2 = 1'b0;
        case (op)
            OP_R: begin
                c[B_REG_WRITE] = 1'b1;
                c[ALU_LSB +: 4] = {f7[5], f3};
                bad = (f7 != 7'h00) && (f7 != 7'h20);
                {use_rd, u1, u2} = 3'b111;
            end
            OP_IMM: begin
                c[B_REG_WRITE] = 1'b1;
                c[B_ALU_SRC] = 1'b1;
                c[ALU_LSB +: 4] = {f7[5] & (f3 == 3'b101), f3};
                // only shift-immediates carry funct7; other OP-IMM use those bits as immediate
                bad = (f3 == 3'b001 || f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20);
                {use_rd, u1} = 2'b11;
            end
            OP_LOAD: begin
                c[B_REG_WRITE] = 1'b1;
                c[B_MEM_TO_REG] = 1'b1;
                c[B_MEM_READ] = 1'b1;
                c[B_ALU_SRC] = 1'b1;
                c[ALU_LSB +: 4] = ALU_ADD;
                c[IMM_LSB +: 3] = IMM_I;
                {use_rd, u1} = 2'b11;
            end
            OP_STORE: begin
                c[B_MEM_WRITE] = 1'b1;
                c[B_ALU_SRC] = 1'b1;
                c[ALU_LSB +: 4] = ALU_ADD;
                c[IMM_LSB +: 3] = IMM_S;
                {u1, u2} = 2'b11;
            end
            OP_BRANCH: begin
                c[B_BRANCH] = 1'b1;
                c[ALU_LSB +: 4] = ALU_SUB;
                c[IMM_LSB +: 3] = IMM_B;
                {u1, u2} = 2'b11;
            end
            OP_JAL: begin
                c[B_JUMP] = 1'b1;
                c[B_REG_WRITE] = 1'b1;
                c[IMM_LSB +: 3] = IMM_J;
                c[PCS_LSB +: 2] = PCS_JAL;
                use_rd = 1'b1;
            end
            OP_JALR: begin
                c[B_JUMP] = 1'b1;
                c[B_REG_WRITE] = 1'b1;
                c[B_ALU_SRC] = 1'b1;
                c[IMM_LSB +: 3] = IMM_I;
                c[PCS_LSB +: 2] = PCS_JALR;
                {use_rd, u1} = 2'b11;
            end
            OP_LUI: begin
                c[B_REG_WRITE] = 1'b1;
                c[B_ALU_SRC] = 1'b1;
                c[ALU_LSB +: 4] = ALU_LUI;
                c[IMM_LSB +: 3] = IMM_U;
                use_rd = 1'b1;
            end
            OP_AUIPC: begin
                c[B_REG_WRITE] = 1'b1;
                c[B_ALU_SRC] = 1'b1;
                c[B_ASEL_PC] = 1'b1;
                c[ALU_LSB +: 4] = ALU_ADD;
                c[IMM_LSB +: 3] = IMM_U;
                use_rd = 1'b1;
            end
            OP_MISC, OP_SYSTEM: c = '0;
            default: bad = 1'b1;
        endcase
    end
    assign oob = (use_rd && {1'b0, instr_i[11:7]} >= NR) ||
                 (u1 && {1'b0, instr_i[19:15]} >= NR) ||
                 (u2 && {1'b0, instr_i[24:20]} >= NR);
    assign illegal_o = bad | oob;
    assign ctrl_o = illegal_o ? '0 : c;
    assign use_rs1_o = u1;
    assign use_rs2_o = u2;
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered decode stage with valid/ready handshake, flush and load-use interlock
//   in_valid/in_ready/in_instr/in_pc   fetch side
//   flush                              drop held entry and current input
//   out_valid/out_ready/out_*          execute side, one-entry pipeline register
//   hazard_cnt                         saturating count of load-use bubbles
module decode_ctrl_stage
    import rv_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ENABLE_HAZARD = 1,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_pc,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  hazard_cnt
);
    logic [CTRL_W-1:0] dec_ctrl;
    logic dec_ill, use_rs1, use_rs2, hazard, accept, valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [4:0] rd_q, rs1_q, rs2_q;
    logic [31:0] pc_q;
    logic ill_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    rv_decode_comb #(.NUM_REGS(NUM_REGS)) u_dec (
        .instr_i   (in_instr),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_ill),
        .use_rs1_o (use_rs1),
        .use_rs2_o (use_rs2)
    );
    assign hazard = (ENABLE_HAZARD != 0) && in_valid && valid_q && ctrl_q[B_MEM_READ] && rd_q != 5'd0 &&
                    ((use_rs1 && in_instr[19:15] == rd_q) || (use_rs2 && in_instr[24:20] == rd_q));
    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign accept = in_valid && in_ready;
    assign valid_d = !flush && (accept || (valid_q && !out_ready));
    // a bubble is only inserted when the load actually drains; flush suppresses it
    assign cnt_d = (hazard && out_ready && !flush && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q <= '0;
            rd_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            pc_q <= '0;
            ill_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q <= cnt_d;
            if (accept) begin
                ctrl_q <= dec_ctrl;
                rd_q <= in_instr[11:7];
                rs1_q <= in_instr[19:15];
                rs2_q <= in_instr[24:20];
                pc_q <= in_pc;
                ill_q <= dec_ill;
            end
        end
    end
    assign out_valid = valid_q;
    assign out_ctrl = ctrl_q;
    assign out_rd = rd_q;
    assign out_rs1 = rs1_q;
    assign out_rs2 = rs2_q;
    assign out_pc = pc_q;
    assign out_illegal = ill_q;
    assign hazard_cnt = cnt_q;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;
    logic clk, rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic in_ready, out_valid, out_illegal;
    logic [17:0] out_ctrl;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [31:0] out_pc;
    logic [15:0] hazard_cnt;
    logic b_in_ready, b_out_valid, b_out_illegal;
    logic [17:0] b_out_ctrl;
    logic [4:0] b_out_rd, b_out_rs1, b_out_rs2;
    logic [31:0] b_out_pc;
    logic [15:0] b_hazard_cnt;
    int checks = 0;
    int failures = 0;
    logic [31:0] tab_instr [7] = '{32'h0020A023, 32'h00208063, 32'h000000EF, 32'h000012B7,
                                   32'hFFFFFFFF, 32'h022081B3, 32'h0000000F};
    logic [31:0] tab_ctrl [7] = '{32'h848, 32'h1090, 32'hA021, 32'h1D41, 32'h0, 32'h0, 32'h0};
    logic tab_ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    decode_ctrl_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_pc(out_pc), .out_illegal(out_illegal), .hazard_cnt(hazard_cnt)
    );
    decode_ctrl_stage #(.NUM_REGS(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_pc(b_out_pc), .out_illegal(b_out_illegal), .hazard_cnt(b_hazard_cnt)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_cnt", hazard_cnt, 0);
        rst = 1'b0;
        step();
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_pc = 32'h100;
        #1 chk("add_in_ready", in_ready, 1);
        step();
        chk("add_valid", out_valid, 1);
        chk("add_ctrl", out_ctrl, 32'h001);
        chk("add_rd", out_rd, 3);
        chk("add_rs1", out_rs1, 1);
        chk("add_rs2", out_rs2, 2);
        chk("add_pc", out_pc, 32'h100);
        in_instr = 32'h402081B3;
        in_pc = 32'h104;
        step();
        chk("sub_ctrl", out_ctrl, 32'h401);
        chk("sub_pc", out_pc, 32'h104);
        in_instr = 32'h00100893;
        step();
        chk("x17_ill16", out_illegal, 1);
        chk("x17_ctrl16", out_ctrl, 0);
        chk("x17_ill32", b_out_illegal, 0);
        chk("x17_ctrl32", b_out_ctrl, 32'h041);
        for (int i = 0; i < 7; i++) begin
            in_instr = tab_instr[i];
            step();
            chk("tab_ctrl", out_ctrl, tab_ctrl[i]);
            chk("tab_ill", out_illegal, tab_ill[i]);
        end
        in_instr = 32'h0000A283;
        step();
        chk("lw_ctrl", out_ctrl, 32'h047);
        chk("lw_rd", out_rd, 5);
        in_instr = 32'h00228333;
        #1 chk("haz_in_ready", in_ready, 0);
        step();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_cnt", hazard_cnt, 1);
        chk("bubble_in_ready", in_ready, 1);
        step();
        chk("after_bubble_valid", out_valid, 1);
        chk("after_bubble_rd", out_rd, 6);
        in_instr = 32'h0000A003;
        step();
        in_instr = 32'h00200333;
        #1 chk("x0_in_ready", in_ready, 1);
        step();
        chk("x0_valid", out_valid, 1);
        chk("x0_rd", out_rd, 6);
        chk("x0_cnt", hazard_cnt, 1);
        in_instr = 32'h0000A283;
        step();
        out_ready = 1'b0;
        in_instr = 32'h00100393;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready, 0);
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_rd", out_rd, 5);
        end
        in_instr = 32'h00228333;
        step();
        step();
        chk("haz_hold_cnt", hazard_cnt, 1);
        chk("haz_hold_rd", out_rd, 5);
        out_ready = 1'b1;
        in_instr = 32'h00100393;
        step();
        chk("tput1_rd", out_rd, 7);
        in_instr = 32'h00200413;
        step();
        chk("tput2_valid", out_valid, 1);
        chk("tput2_rd", out_rd, 8);
        flush = 1'b1;
        in_instr = 32'h00001217;
        in_pc = 32'h300;
        #1 chk("flush_in_ready", in_ready, 0);
        step();
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush_drop_valid", out_valid, 0);
        chk("flush_drop_pc", out_pc, 32'h104 + 32'h0);
        in_valid = 1'b1;
        in_pc = 32'h200;
        step();
        chk("auipc_ctrl", out_ctrl, 32'h11841);
        chk("auipc_aselpc", out_ctrl[16], 1);
        chk("auipc_imm", out_ctrl[13:11], 3);
        chk("auipc_rd", out_rd, 4);
        chk("auipc_pc", out_pc, 32'h200);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ctrl", out_ctrl, 0);
        chk("arst_rd", out_rd, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_cnt", hazard_cnt, 0);
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
